// File: rtl/aes_inv_sub_bytes_seq.sv
// aes_inv_sub_bytes_seq
// Sequential AES InvSubBytes over one 128-bit state. A captured state is
// rewritten in place, LANES bytes per cycle, through LANES copies of the
// inverse S-box. The result is presented from the same register.
//
// Handshakes: both ports are valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. Once out_valid rises, it stays
// high with out_data stable until the transfer completes. in_ready is high
// only in IDLE.
module aes_inv_sub_bytes_seq #(
    parameter int LANES = 1   // bytes substituted per cycle: 1, 2 or 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [1:0]   fsm_state
);

    localparam logic [3:0] STEP = 4'(LANES);
    localparam logic [3:0] LAST = 4'(16 - LANES);

    // FIPS-197 inverse S-box. Entry 0 is the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Pure lookup; {~b, 3'b000} is the bit offset of entry b.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [127:0]   data_q;
    logic [127:0]   data_run;
    logic [3:0]     cnt_q;
    logic [3:0]     lane_idx [LANES];
    logic [7:0]     lane_sub [LANES];

    // One inverse S-box per lane. Byte i sits at bit offset 8*(15-i),
    // which for a 4-bit index is simply {~i, 3'b000}.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = cnt_q + 4'(l);
        assign lane_sub[l] = inv_sbox(data_q[{~lane_idx[l], 3'b000} +: 8]);
    end

    // State register with the current byte group replaced by its substitutes
    always_comb begin
        data_run = data_q;
        for (int l = 0; l < LANES; l++) begin
            data_run[{~lane_idx[l], 3'b000} +: 8] = lane_sub[l];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; out_data comes straight from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        fsm_state = state_q;
        out_data  = data_q;
    end

    // Datapath: capture on accept, rewrite one group per RUN cycle,
    // hold in DONE so the result stays stable under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 128'h0;
            cnt_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        cnt_q  <= 4'd0;
                    end
                end
                RUN: begin
                    data_q <= data_run;
                    if (cnt_q == LAST) begin
                        cnt_q <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + STEP;
                    end
                end
                default: begin
                    data_q <= data_q;
                    cnt_q  <= cnt_q;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_inv_sub_bytes_seq.md
AES_INV_SUB_BYTES_SEQ -- requirements
Module: aes_inv_sub_bytes_seq

Interface
REQ-001 SHALL have parameter LANES, default 1, giving the number of state bytes substituted per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data holds a valid 128-bit AES state.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a state this cycle.
REQ-006 SHALL have port in_data, input, 128 bits: input state; byte i = in_data[127-8i : 120-8i], so byte 0 is the MSB byte.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream block accepts the result.
REQ-009 SHALL have port out_data, output, 128 bits: InvSubBytes(in_data), using the same byte ordering as in_data.
REQ-010 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-011 SHALL contain its own 256-entry FIPS-197 inverse S-box, purely combinational, instantiated LANES times.
- The forward S-box is not used.
- No other module is instantiated.
REQ-012 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready=1 and out_valid=0.
- On in_valid && in_ready, SHALL capture in_data into the internal state register, clear byte counter cnt to 0, and go to RUN.
REQ-014 In RUN, each cycle SHALL replace bytes cnt .. cnt+LANES-1 of the state register with their inverse S-box values.
- cnt then advances by LANES.
REQ-015 When the final group is written (cnt = 16-LANES), SHALL go to DONE on the same edge.
- cnt wraps to 0; cnt never indexes beyond byte 15.
REQ-016 Latency: if the input handshake occurs at edge k, out_valid SHALL first be high after edge k+16/LANES.
- That is 16, 8 or 4 cycles.
REQ-017 In DONE, out_valid=1 and out_data SHALL hold the full result, stable until the handshake completes.
- On out_valid && out_ready, SHALL go to IDLE.
- If out_ready stays low, SHALL remain in DONE indefinitely with out_data unchanged.
REQ-018 in_ready SHALL be 0 in RUN and DONE.
- in_valid and in_data SHALL be ignored in those states.
- A new state cannot be accepted in the same cycle as the output handshake; there is a one-cycle IDLE bubble between jobs.
REQ-019 out_data SHALL be driven directly from the state register (registered output, no combinational path from in_data).
- Its value outside DONE is don't-care for checking but SHALL never be X after reset.
REQ-020 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-021 When rst=1 at a rising edge, the block SHALL enter IDLE.
- Resulting values: in_ready=1, out_valid=0, busy=0, cnt=0, state register=128'h0, so out_data=0.
REQ-022 Reset SHALL take priority over every handshake.
- Asserted in RUN or DONE, it SHALL abort the job and discard the partial result.
- The first handshake after rst deasserts SHALL start a fresh job.

Verification
REQ-023 LANES=1, in_data=637c777bf26b6fc53001672bfed7ab76 with out_ready=1 -> after 16 cycles, out_valid=1 for one cycle and out_data=000102030405060708090a0b0c0d0e0f.
REQ-024 LANES=4, in_data=0x00 repeated 16 times -> after 4 cycles, out_data=0x52 repeated 16 times; a second job with 0xff repeated 16 times -> out_data=0x7d repeated 16 times.
REQ-025 Back-pressure test: hold out_ready=0 for 20 cycles after DONE -> out_valid stays 1, out_data stays constant, and in_ready stays 0 throughout. Then pulse out_ready -> next cycle shows IDLE with in_ready=1.
REQ-026 Ignored-input test: in_valid=1 with changing in_data during RUN -> result equals InvSubBytes of the originally captured state only.
REQ-027 Reset mid-job: rst=1 for 1 cycle at cnt=7 (LANES=1) -> in_ready=1, out_valid=0, out_data=0 next cycle. A new job with ca b7 04 09 in bytes 0..3 (rest 0x63) -> bytes 0..3 = 10 20 30 40, rest 0x00.
REQ-028 Sweep test: inputs 0x00..0xff spread across 16 jobs, compared against a golden inverse table -> zero mismatches.
